// File: rtl/fc_score_engine_pkg.sv
// fc_score_engine_pkg: shared widths, saturation limits, FSM states and saturation helper
package fc_score_engine_pkg;
  localparam int INTERNAL_BITS = 32;
  localparam int ACC_BITS = 2 * INTERNAL_BITS;
  localparam logic signed [INTERNAL_BITS-1:0] MAX_S = 32'sh7FFFFFFF;
  localparam logic signed [INTERNAL_BITS-1:0] MIN_S = 32'sh80000000;
  typedef enum logic [2:0] {S_IDLE, S_MAC, S_STORE, S_EMIT, S_DONE} state_t;
  // clamp a widened sum: it fits only when every bit above the result sign bit matches it
  function automatic logic signed [INTERNAL_BITS-1:0] sat_ib(input logic signed [ACC_BITS:0] v);
    sat_ib = (&v[ACC_BITS:INTERNAL_BITS-1] | ~|v[ACC_BITS:INTERNAL_BITS-1]) ?
             v[INTERNAL_BITS-1:0] : (v[ACC_BITS] ? MIN_S : MAX_S);
  endfunction
endpackage

// File: rtl/fc_score_engine_if.sv
// fc_score_engine_if: start/status, feature/weight/bias memory ports and score stream
interface fc_score_engine_if #(parameter int ADDR_W = 16);
  import fc_score_engine_pkg::*;
  logic start;
  logic [ADDR_W-1:0] feat_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] bias_addr;
  logic signed [INTERNAL_BITS-1:0] feat_rdata;
  logic signed [INTERNAL_BITS-1:0] w_rdata;
  logic signed [INTERNAL_BITS-1:0] bias_rdata;
  logic signed [INTERNAL_BITS-1:0] score_out;
  logic score_valid;
  logic busy;
  logic done;
  modport master (
    input  start, feat_rdata, w_rdata, bias_rdata,
    output feat_addr, w_addr, bias_addr, score_out, score_valid, busy, done
  );
  modport slave (
    output start, feat_rdata, w_rdata, bias_rdata,
    input  feat_addr, w_addr, bias_addr, score_out, score_valid, busy, done
  );
endinterface

// File: rtl/fc_score_engine_sat_round.sv
// fc_sat_round: arithmetic shift, bias add and saturation to INTERNAL_BITS
module fc_sat_round import fc_score_engine_pkg::*; #(
  parameter int FRAC_BITS = 0
) (
  input  logic signed [ACC_BITS-1:0]      i_acc,
  input  logic signed [INTERNAL_BITS-1:0] i_bias,
  output logic signed [INTERNAL_BITS-1:0] o_s
);
  logic signed [ACC_BITS-1:0] w_sh;
  logic signed [ACC_BITS:0]   w_sum;
  assign w_sh  = i_acc >>> FRAC_BITS;
  assign w_sum = {w_sh[ACC_BITS-1], w_sh} +
                 {{(ACC_BITS+1-INTERNAL_BITS){i_bias[INTERNAL_BITS-1]}}, i_bias};
  assign o_s   = sat_ib(w_sum);
endmodule

// File: rtl/fc_score_engine.sv
// fc_score_engine: per-class dot product + bias, buffered and emitted as one unbroken burst
module fc_score_engine import fc_score_engine_pkg::*; #(
  parameter int IN_LEN    = 16,
  parameter int NUM_CLASS = 10,
  parameter int FRAC_BITS = 0,
  parameter int ADDR_W    = 16
) (
  input logic               i_clk,
  input logic               i_rst_n,
  fc_score_engine_if.master bus
);
  localparam int IW = $clog2(IN_LEN + 1);
  localparam int CW = $clog2(NUM_CLASS + 1);
  state_t r_state;
  logic [IW-1:0] r_i;
  logic [CW-1:0] r_cls;
  logic [CW-1:0] r_e;
  logic signed [ACC_BITS-1:0] r_acc;
  logic signed [INTERNAL_BITS-1:0] r_buf [NUM_CLASS];
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_feat_addr;
  logic [ADDR_W-1:0] r_w_addr;
  logic [ADDR_W-1:0] r_bias_addr;
  logic signed [INTERNAL_BITS-1:0] r_score;
  logic r_valid;
  logic r_busy;
  logic r_done;
  logic signed [ACC_BITS-1:0] w_prod;
  logic signed [INTERNAL_BITS-1:0] w_s;
  logic [CW-1:0] w_e_nx;
  assign w_prod = ACC_BITS'(bus.feat_rdata) * ACC_BITS'(bus.w_rdata);
  assign w_e_nx = r_e + CW'(1);
  fc_sat_round #(.FRAC_BITS(FRAC_BITS)) u_sat (
    .i_acc (r_acc),
    .i_bias(bus.bias_rdata),
    .o_s   (w_s)
  );
  // job sequencer: memory addressing runs one cycle ahead of the data it multiplies
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_i         <= '0;
      r_cls       <= '0;
      r_e         <= '0;
      r_acc       <= '0;
      r_base      <= '0;
      r_feat_addr <= '0;
      r_w_addr    <= '0;
      r_bias_addr <= '0;
      r_score     <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++) r_buf[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_state     <= S_MAC;
          r_busy      <= 1'b1;
          r_i         <= '0;
          r_cls       <= '0;
          r_acc       <= '0;
          r_base      <= '0;
          r_feat_addr <= '0;
          r_w_addr    <= '0;
          r_bias_addr <= '0;
        end
        S_MAC: begin
          if (r_i != '0) r_acc <= r_acc + w_prod;
          if (r_i == IW'(IN_LEN)) r_state <= S_STORE;
          else begin
            r_i <= r_i + IW'(1);
            if (r_i != IW'(IN_LEN - 1)) begin
              r_feat_addr <= r_feat_addr + ADDR_W'(1);
              r_w_addr    <= r_w_addr + ADDR_W'(1);
            end
          end
        end
        S_STORE: begin
          r_buf[r_cls] <= w_s;
          if (r_cls == CW'(NUM_CLASS - 1)) begin
            r_state     <= S_EMIT;
            r_e         <= '0;
            r_valid     <= 1'b1;
            r_score     <= (r_cls == '0) ? w_s : r_buf[0];
            r_feat_addr <= '0;
            r_w_addr    <= '0;
            r_bias_addr <= '0;
          end else begin
            r_state     <= S_MAC;
            r_cls       <= r_cls + CW'(1);
            r_i         <= '0;
            r_acc       <= '0;
            r_base      <= r_base + ADDR_W'(IN_LEN);
            r_feat_addr <= '0;
            r_w_addr    <= r_base + ADDR_W'(IN_LEN);
            r_bias_addr <= r_bias_addr + ADDR_W'(1);
          end
        end
        S_EMIT: begin
          if (r_e == CW'(NUM_CLASS - 1)) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_score <= '0;
            r_done  <= 1'b1;
          end else begin
            r_e     <= w_e_nx;
            r_score <= r_buf[w_e_nx];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.feat_addr   = r_feat_addr;
  assign bus.w_addr      = r_w_addr;
  assign bus.bias_addr   = r_bias_addr;
  assign bus.score_out   = r_score;
  assign bus.score_valid = r_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
endmodule

// File: tb/tb_fc_score_engine.sv
// tb_fc_score_engine: three configurations checked against a cycle-timing/arithmetic model
module tb_fc_score_engine;
  logic clk;
  logic rst_n;
  logic [2:0] st;
  int n_cmp;
  int n_bad;
  logic signed [31:0] feat_mem [64];
  logic signed [31:0] w_mem [64];
  logic signed [31:0] bias_mem [64];
  logic signed [31:0] qv [$];
  int t [3];
  logic [31:0] ev [3][4];
  int dec_on, dec_idx, dec_pos, last_idx, last_len;
  logic signed [31:0] dec_best;
  fc_score_engine_if #(.ADDR_W(16)) ifa ();
  fc_score_engine_if #(.ADDR_W(16)) ifb ();
  fc_score_engine_if #(.ADDR_W(16)) ifc ();
  fc_score_engine #(.IN_LEN(4), .NUM_CLASS(3), .FRAC_BITS(0), .ADDR_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa.master));
  fc_score_engine #(.IN_LEN(4), .NUM_CLASS(3), .FRAC_BITS(8), .ADDR_W(16)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb.master));
  fc_score_engine #(.IN_LEN(1), .NUM_CLASS(1), .FRAC_BITS(0), .ADDR_W(16)) dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifc.master));
  logic [2:0] vl, dn, bz;
  logic [31:0] so [3];
  assign ifa.start = st[0];
  assign ifb.start = st[1];
  assign ifc.start = st[2];
  assign vl = {ifc.score_valid, ifb.score_valid, ifa.score_valid};
  assign dn = {ifc.done, ifb.done, ifa.done};
  assign bz = {ifc.busy, ifb.busy, ifa.busy};
  assign so[0] = ifa.score_out;
  assign so[1] = ifb.score_out;
  assign so[2] = ifc.score_out;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // one-cycle-latency memories shared by all three engines
  always @(posedge clk) begin
    ifa.feat_rdata <= feat_mem[ifa.feat_addr[5:0]];
    ifa.w_rdata    <= w_mem[ifa.w_addr[5:0]];
    ifa.bias_rdata <= bias_mem[ifa.bias_addr[5:0]];
    ifb.feat_rdata <= feat_mem[ifb.feat_addr[5:0]];
    ifb.w_rdata    <= w_mem[ifb.w_addr[5:0]];
    ifb.bias_rdata <= bias_mem[ifb.bias_addr[5:0]];
    ifc.feat_rdata <= feat_mem[ifc.feat_addr[5:0]];
    ifc.w_rdata    <= w_mem[ifc.w_addr[5:0]];
    ifc.bias_rdata <= bias_mem[ifc.bias_addr[5:0]];
  end
  function automatic int pl(int k); return (k == 2) ? 1 : 4; endfunction
  function automatic int pn(int k); return (k == 2) ? 1 : 3; endfunction
  function automatic int pf(int k); return (k == 1) ? 8 : 0; endfunction
  function automatic logic [31:0] exp_score(int k, int c);
    longint a;
    longint sh;
    logic signed [65:0] s;
    a = 0;
    for (int i = 0; i < pl(k); i++) a += longint'(feat_mem[i]) * longint'(w_mem[c * pl(k) + i]);
    sh = a >>> pf(k);
    s = $signed({{2{sh[63]}}, sh}) + $signed({{34{bias_mem[c][31]}}, bias_mem[c]});
    if (s > 66'sd2147483647) return 32'h7FFFFFFF;
    if (s < -66'sd2147483648) return 32'h80000000;
    return s[31:0];
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", nm, $signed(act), act, $signed(exp), exp);
    end
  endtask
  // model: t = cycles since the edge that accepted start, -1 when idle
  initial begin
    t = '{-1, -1, -1};
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) t[k] = -1;
        else if (t[k] >= 0) t[k] = (t[k] == pn(k) * (pl(k) + 2) + pn(k)) ? -1 : t[k] + 1;
        else if (st[k]) begin
          t[k] = 0;
          for (int c = 0; c < pn(k); c++) ev[k][c] = exp_score(k, c);
        end
      end
    end
  end
  // compare every cycle, collect the score stream and track argmax of engine A's burst
  initial begin
    dec_on = 0;
    last_idx = -1;
    last_len = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        int t0;
        logic ebz, evl, edn;
        logic [31:0] eso;
        t0 = pn(k) * (pl(k) + 2);
        ebz = t[k] >= 0;
        evl = t[k] >= t0 && t[k] < t0 + pn(k);
        edn = t[k] == t0 + pn(k);
        eso = evl ? ev[k][t[k] - t0] : 32'd0;
        n_cmp++;
        if ({bz[k], vl[k], dn[k], so[k]} !== {ebz, evl, edn, eso}) begin
          n_bad++;
          $display("FAIL cycle dut%0d t=%0d: busy/valid/done/score got %b%b%b %0d, want %b%b%b %0d",
                   k, t[k], bz[k], vl[k], dn[k], $signed(so[k]), ebz, evl, edn, $signed(eso));
        end
        if (vl[k]) qv.push_back(so[k]);
      end
      if (vl[0]) begin
        if (dec_on == 0) begin
          dec_on = 1; dec_best = so[0]; dec_idx = 0; dec_pos = 1;
        end else begin
          if ($signed(so[0]) > dec_best) begin dec_best = so[0]; dec_idx = dec_pos; end
          dec_pos++;
        end
      end else if (dec_on != 0) begin
        dec_on = 0; last_idx = dec_idx; last_len = dec_pos;
      end
    end
  end
  task automatic run(input int k, output int lat, output int gap);
    @(negedge clk); st[k] = 1'b1;
    @(negedge clk); st[k] = 1'b0;
    lat = 0;
    while (!vl[k] && lat < 500) begin @(negedge clk); lat++; end
    gap = 0;
    while (!dn[k] && gap < 500) begin @(negedge clk); gap++; end
    chk("done_seen", {31'd0, dn[k]}, 32'd1);
    @(negedge clk);
  endtask
  task automatic qchk(input string nm, input int n, input logic [31:0] e0, e1, e2);
    logic [31:0] e [3];
    e = '{e0, e1, e2};
    chk({nm, "_count"}, qv.size(), n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_%0d", nm, i), qv[i], e[i]);
  endtask
  task automatic clr_mem;
    for (int i = 0; i < 64; i++) begin feat_mem[i] = 0; w_mem[i] = 0; bias_mem[i] = 0; end
  endtask
  initial begin
    int lat, gap;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; st = 3'b000;
    clr_mem();
    repeat (3) @(negedge clk);
    chk("rst_feat_addr", {16'd0, ifa.feat_addr}, 0);
    chk("rst_w_addr", {16'd0, ifa.w_addr}, 0);
    chk("rst_bias_addr", {16'd0, ifa.bias_addr}, 0);
    chk("rst_flags", {29'd0, ifa.busy, ifa.score_valid, ifa.done}, 0);
    #2 rst_n = 1'b1;
    // all-ones dot product
    for (int i = 0; i < 4; i++) feat_mem[i] = 1;
    for (int i = 0; i < 12; i++) w_mem[i] = 1;
    qv.delete(); run(0, lat, gap);
    chk("t1_latency", lat, 18);
    chk("t1_done_gap", gap, 3);
    qchk("t1", 3, 4, 4, 4);
    // positive and negative saturation without accumulator wrap
    clr_mem();
    feat_mem[0] = 32'h7FFFFFFF; feat_mem[1] = 32'h7FFFFFFF;
    for (int i = 0; i < 12; i++) w_mem[i] = 32'h7FFFFFFF;
    qv.delete(); run(0, lat, gap);
    qchk("t2_max", 3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    for (int i = 0; i < 12; i++) w_mem[i] = 32'h80000000;
    qv.delete(); run(0, lat, gap);
    qchk("t2_min", 3, 32'h80000000, 32'h80000000, 32'h80000000);
    // fraction shift applied before bias
    clr_mem();
    for (int i = 0; i < 4; i++) feat_mem[i] = 256;
    for (int i = 0; i < 12; i++) w_mem[i] = 512;
    bias_mem[0] = 0; bias_mem[1] = 1; bias_mem[2] = -2048;
    qv.delete(); run(1, lat, gap);
    qchk("t3", 3, 2048, 2049, 0);
    // start held during MAC and during EMIT
    clr_mem();
    for (int i = 0; i < 4; i++) feat_mem[i] = i + 1;
    for (int c = 0; c < 3; c++) begin
      w_mem[c*4] = c + 1; w_mem[c*4+1] = -1; w_mem[c*4+2] = 0; w_mem[c*4+3] = 2;
    end
    bias_mem[0] = 10; bias_mem[1] = -3; bias_mem[2] = 0;
    qv.delete();
    @(negedge clk); st[0] = 1'b1;
    repeat (8) @(negedge clk);
    st[0] = 1'b0;
    lat = 0;
    while (!vl[0] && lat < 500) begin @(negedge clk); lat++; end
    st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    gap = 0;
    while (!dn[0] && gap < 500) begin @(negedge clk); gap++; end
    chk("t4_done_seen", {31'd0, dn[0]}, 32'd1);
    repeat (2) @(negedge clk);
    qchk("t4_hold", 3, 17, 5, 9);
    // reset mid-MAC discards the job
    qv.delete();
    @(negedge clk); st[0] = 1'b1;
    @(negedge clk); st[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", {31'd0, ifa.busy}, 0);
    chk("t4_rst_feat_addr", {16'd0, ifa.feat_addr}, 0);
    chk("t4_rst_w_addr", {16'd0, ifa.w_addr}, 0);
    chk("t4_rst_bias_addr", {16'd0, ifa.bias_addr}, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_no_partial", qv.size(), 0);
    run(0, lat, gap);
    qchk("t4_rerun", 3, 17, 5, 9);
    // argmax downstream sees one unbroken burst
    clr_mem();
    feat_mem[0] = 1; w_mem[0] = -5; w_mem[4] = 7; w_mem[8] = 3;
    qv.delete(); run(0, lat, gap);
    qchk("t5", 3, -5, 7, 3);
    chk("t5_argmax", last_idx, 1);
    chk("t5_burst_len", last_len, 3);
    // single input, single class
    clr_mem();
    feat_mem[0] = 6; w_mem[0] = -7; bias_mem[0] = 100;
    qv.delete(); run(2, lat, gap);
    chk("t6_latency", lat, 3);
    chk("t6_done_gap", gap, 1);
    qchk("t6", 1, 58, 0, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
